// File: rtl/mem_access_unit_if.sv
// Request/response and word-memory signals shared by the load/store front end,
// its requester and the word-wide data memory.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // slave is the load/store unit; master is the requester plus the memory behind it
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide data memory: RV32I byte/half/word accesses,
// sub-word stores by read-modify-write, misaligned or illegal requests rejected.
module mem_access_unit #(
    parameter int READ_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_enable,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic        req_err;
    logic        req_sw;

    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic        half,
                                                input logic [1:0]  lane,
                                                input logic [15:0] wdata,
                                                input logic [31:0] word);
        logic [31:0] mask;
        logic [31:0] data;
        if (half) begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            data = {16'b0, wdata} << {lane[1], 4'b0000};
        end else begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'b0, wdata[7:0]} << {lane, 3'b000};
        end
        return (word & ~mask) | data;
    endfunction

    // NOTE: each always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        req_err = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = bus.req_addr[0];
            3'b010:         req_err = |bus.req_addr[1:0];
            default:        req_err = 1'b1;
        endcase
    end

    assign req_sw = bus.req_store && (bus.req_funct3 == 3'b010);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)     state_d = RESP;
                    else if (req_sw) state_d = WRITE;
                    else             state_d = READ;
                end
            end
            READ:    if (cnt_q == 3'd1) state_d = store_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (clk_enable) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            store_q     <= 1'b0;
            funct3_q    <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else if (clk_enable) begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        store_q     <= bus.req_store;
                        funct3_q    <= bus.req_funct3;
                        lane_q      <= bus.req_addr[1:0];
                        wdata_q     <= bus.req_wdata[15:0];
                        resp_data_q <= '0;
                        resp_err_q  <= req_err;
                        // Rejected requests leave the memory-side registers untouched
                        if (!req_err) begin
                            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                            cnt_q      <= 3'(READ_LATENCY);
                            if (req_sw) mem_wdata_q <= bus.req_wdata;
                        end
                    end
                end
                READ: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        if (store_q) mem_wdata_q <= store_merge(funct3_q[0], lane_q, wdata_q, bus.mem_rdata);
                        else         resp_data_q <= load_extend(funct3_q, lane_q, bus.mem_rdata);
                    end
                end
                RESP: begin
                    resp_data_q <= '0;
                    resp_err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, stall and reset sequences,
// then randomized requests checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_enable = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit #(.READ_LATENCY(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    // Word memory with L enabled edges from address to usable read data
    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe [0:6];
    int          wr_count = 0;
    logic [31:0] last_waddr = '0;

    always @(posedge clk) begin
        if (clk_enable) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
                wr_count   <= wr_count + 1;
                last_waddr <= bus.mem_addr;
            end
            rd_pipe[0] <= mem[bus.mem_addr[11:2]];
            for (int i = 1; i < 7; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    if (L == 1) begin : g_rd_comb
        assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
    end else begin : g_rd_pipe
        assign bus.mem_rdata = rd_pipe[L-2];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: result of one request from the RV32I rules, using plain arithmetic
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] word,
                                  output logic [31:0] d, output logic e, output int lat,
                                  output int nw, output logic [31:0] nword);
        int size;
        int sh;
        logic [31:0] raw;
        logic [31:0] mask;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        sh    = 8 * int'(a % 4);
        e     = (f3 == 3'd3) || (f3 >= 3'd6) || ((a % size) != 0);
        d     = '0;
        nword = word;
        lat   = 0;
        nw    = 0;
        if (e) return;
        if (!st) begin
            raw = word >> sh;
            if (size == 4) d = word;
            else begin
                d = raw % (32'd1 << (8 * size));
                if (!f3[2] && d >= (32'd1 << (8 * size - 1))) d = d - (32'd1 << (8 * size));
            end
            lat = L;
        end else begin
            mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1) << sh;
            nword = (word & ~mask) | ((wd << sh) & mask);
            lat   = (size == 4) ? 1 : L + 1;
            nw    = 1;
        end
    endfunction

    // One request: accept, then count enabled edges until resp_valid; optional stalls
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int stall_at, input int stall_len,
                           input bit rand_en, output logic [31:0] d, output logic e,
                           output int en_edges, output int cycles, output int writes);
        int w0;
        int stalled;
        bit got;
        logic [31:0] s_addr, s_wdata, s_data;
        logic [3:0]  s_ctl;
        w0 = wr_count;
        @(negedge clk);
        check("ready_before", 32'(bus.req_ready), 32'd1);
        clk_enable     = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        en_edges = 0;
        cycles   = 0;
        stalled  = 0;
        got      = 1'b0;
        for (int b = 0; b < 100; b++) begin
            if (bus.resp_valid) begin
                got = 1'b1;
                break;
            end
            if (stall_len > 0 && en_edges == stall_at && stalled < stall_len) begin
                clk_enable = 1'b0;
                stalled++;
            end else begin
                clk_enable = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            s_addr  = bus.mem_addr;
            s_wdata = bus.mem_wdata;
            s_data  = bus.resp_data;
            s_ctl   = {bus.mem_we, bus.resp_valid, bus.req_ready, bus.resp_err};
            @(posedge clk);
            cycles++;
            if (clk_enable) en_edges++;
            @(negedge clk);
            if (!clk_enable) begin
                check("frozen_addr", bus.mem_addr, s_addr);
                check("frozen_wdata", bus.mem_wdata, s_wdata);
                check("frozen_data", bus.resp_data, s_data);
                check("frozen_ctl", 32'({bus.mem_we, bus.resp_valid, bus.req_ready, bus.resp_err}), 32'(s_ctl));
            end
        end
        if (!got) check("resp_timeout", 32'(bus.resp_valid), 32'd1);
        d = bus.resp_data;
        e = bus.resp_err;
        clk_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("resp_pulse", 32'({bus.resp_valid, bus.req_ready}), 32'b01);
        writes = wr_count - w0;
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        logic [31:0] d;
        logic e;
        int en, cy, w;
        run_req(1'b1, 3'b010, a, v, -1, 0, 1'b0, d, e, en, cy, w);
    endtask

    typedef struct {
        string       name;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vq[$];
    logic [31:0] ref_mem [0:63];

    task automatic add(input string n, input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] init, input logic [31:0] ed,
                       input logic ee, input int el, input int ew, input logic [31:0] eword);
        vec_t v;
        v = '{n, st, f3, a, wd, init, ed, ee, el, ew, eword};
        vq.push_back(v);
    endtask

    initial begin
        logic [31:0] d, ed, nword;
        logic e, ee;
        int en, cy, w, el, ew, seen, w0;
        logic [2:0] st_codes [0:5];

        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        clk_enable     = 1'b1;

        add("lw",      0, 3'b010, 32'h100, 0, 32'h8899AABB, 32'h8899AABB, 0, 2, 0, 32'h8899AABB);
        add("lb",      0, 3'b000, 32'h103, 0, 32'h8899AABB, 32'hFFFFFF88, 0, 2, 0, 32'h8899AABB);
        add("lbu",     0, 3'b100, 32'h103, 0, 32'h8899AABB, 32'h00000088, 0, 2, 0, 32'h8899AABB);
        add("lh",      0, 3'b001, 32'h102, 0, 32'h8899AABB, 32'hFFFF8899, 0, 2, 0, 32'h8899AABB);
        add("lhu",     0, 3'b101, 32'h100, 0, 32'h8899AABB, 32'h0000AABB, 0, 2, 0, 32'h8899AABB);
        add("lb0",     0, 3'b000, 32'h100, 0, 32'h8899AABB, 32'hFFFFFFBB, 0, 2, 0, 32'h8899AABB);
        add("lbu1",    0, 3'b100, 32'h101, 0, 32'h8899AABB, 32'h000000AA, 0, 2, 0, 32'h8899AABB);
        add("lh_pos",  0, 3'b001, 32'h200, 0, 32'h12347FFF, 32'h00007FFF, 0, 2, 0, 32'h12347FFF);
        add("sb",      1, 3'b000, 32'h101, 32'h55, 32'h11223344, 0, 0, 3, 1, 32'h11225544);
        add("sh",      1, 3'b001, 32'h102, 32'hBEEF, 32'h11223344, 0, 0, 3, 1, 32'hBEEF3344);
        add("sb3",     1, 3'b000, 32'h203, 32'hFFFFFFA5, 32'h11223344, 0, 0, 3, 1, 32'hA5223344);
        add("sh0",     1, 3'b001, 32'h200, 32'h1234CAFE, 32'h11223344, 0, 0, 3, 1, 32'h1122CAFE);
        add("sw",      1, 3'b010, 32'h7FC, 32'hDEADBEEF, 32'h0, 0, 0, 1, 1, 32'hDEADBEEF);
        add("lw_mis",  0, 3'b010, 32'h102, 0, 32'h8899AABB, 0, 1, 0, 0, 32'h8899AABB);
        add("lh_mis",  0, 3'b001, 32'h101, 0, 32'h8899AABB, 0, 1, 0, 0, 32'h8899AABB);
        add("f3_011",  0, 3'b011, 32'h100, 0, 32'h8899AABB, 0, 1, 0, 0, 32'h8899AABB);
        add("st_110",  1, 3'b110, 32'h100, 32'h12345678, 32'h11223344, 0, 1, 0, 0, 32'h11223344);
        add("sw_mis",  1, 3'b010, 32'h7FE, 32'h12345678, 32'h55667788, 0, 1, 0, 0, 32'h55667788);
        add("sh_mis",  1, 3'b001, 32'h103, 32'h12345678, 32'h55667788, 0, 1, 0, 0, 32'h55667788);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            poke({vq[i].addr[31:2], 2'b00}, vq[i].init);
            run_req(vq[i].st, vq[i].f3, vq[i].addr, vq[i].wdata, -1, 0, 1'b0, d, e, en, cy, w);
            check({vq[i].name, "_data"}, d, vq[i].exp_data);
            check({vq[i].name, "_err"}, 32'(e), 32'(vq[i].exp_err));
            check({vq[i].name, "_lat"}, 32'(en), 32'(vq[i].exp_lat));
            check({vq[i].name, "_writes"}, 32'(w), 32'(vq[i].exp_wr));
            check({vq[i].name, "_word"}, mem[vq[i].addr[11:2]], vq[i].exp_word);
            if (vq[i].exp_wr == 1) check({vq[i].name, "_waddr"}, last_waddr, {vq[i].addr[31:2], 2'b00});
        end

        // Stall of 3 cycles while reading
        poke(32'h100, 32'h8899AABB);
        run_req(0, 3'b001, 32'h102, 0, 1, 3, 1'b0, d, e, en, cy, w);
        check("stall_rd_data", d, 32'hFFFF8899);
        check("stall_rd_cycles", 32'(cy), 32'(L + 3));
        check("stall_rd_writes", 32'(w), 32'd0);

        // Stall of 3 cycles while the sub-word write strobe is up
        poke(32'h100, 32'h11223344);
        run_req(1, 3'b000, 32'h101, 32'h55, L, 3, 1'b0, d, e, en, cy, w);
        check("stall_sb_cycles", 32'(cy), 32'(L + 1 + 3));
        check("stall_sb_writes", 32'(w), 32'd1);
        check("stall_sb_word", mem[64], 32'h11225544);

        run_req(1, 3'b010, 32'h7FC, 32'hCAFEF00D, 0, 3, 1'b0, d, e, en, cy, w);
        check("stall_sw_cycles", 32'(cy), 32'd4);
        check("stall_sw_writes", 32'(w), 32'd1);
        check("stall_sw_word", mem[511], 32'hCAFEF00D);

        // Reset while reading: no response afterwards
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_rd_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rd_addr", bus.mem_addr, 32'd0);
        check("rst_rd_wdata", bus.mem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("rst_rd_no_resp", 32'(seen), 32'd0);

        // Reset while the write strobe is up: the write is dropped
        poke(32'h100, 32'h11223344);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h101; bus.req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        seen = 0;
        for (int b = 0; b < 10 && !bus.mem_we; b++) @(negedge clk);
        check("rst_wr_reach_write", 32'(bus.mem_we), 32'd1);
        w0 = wr_count;
        rst_n = 1'b0;
        #1;
        check("rst_wr_we", 32'(bus.mem_we), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("rst_wr_no_resp", 32'(seen), 32'd0);
        check("rst_wr_writes", 32'(wr_count - w0), 32'd0);
        check("rst_wr_word", mem[64], 32'h11223344);

        // Randomized requests over a 64-word window, random clock-enable stalls
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            poke(32'(i * 4), ref_mem[i]);
        end
        st_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        for (int n = 0; n < 300; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a, wd;
            st = 1'($urandom);
            f3 = st ? st_codes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            wd = $urandom;
            model(st, f3, a, wd, ref_mem[a[7:2]], ed, ee, el, ew, nword);
            run_req(st, f3, a, wd, -1, 0, 1'b1, d, e, en, cy, w);
            check("rnd_data", d, ed);
            check("rnd_err", 32'(e), 32'(ee));
            check("rnd_lat", 32'(en), 32'(el));
            check("rnd_writes", 32'(w), 32'(ew));
            ref_mem[a[7:2]] = nword;
            check("rnd_word", mem[a[7:2]], ref_mem[a[7:2]]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
